// File: rtl/adc_pack_pkg.sv
// Shared types and constants for the AD9826 frame packer.
// Holds the FSM state encoding, RAM word / header layouts, and field widths.
// Optional feature macro used by the packer: ADC_PACK_HDR_EN (frame header word).
package adc_pack_pkg;

    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned PIX_W          = 16;
    localparam int unsigned WORD_W         = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned PIX_NUM_W      = 10;
    localparam int unsigned FRAME_CNT_W    = 16;
    localparam int unsigned DROP_CNT_W     = 8;

    // Header word field layout: {frame count, pad, pixel count}
    localparam int unsigned HDR_N_LSB   = 0;
    localparam int unsigned HDR_N_W     = 10;
    localparam int unsigned HDR_PAD_W   = 6;
    localparam int unsigned HDR_CNT_LSB = HDR_N_LSB + HDR_N_W + HDR_PAD_W;
    localparam int unsigned HDR_CNT_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_HDR     = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Data word: odd pixel in the upper half, even pixel in the lower half
    typedef struct packed {
        logic [PIX_W-1:0] pix_odd;
        logic [PIX_W-1:0] pix_even;
    } ram_word_t;

    typedef struct packed {
        logic [HDR_CNT_W-1:0] frame_cnt;
        logic [HDR_PAD_W-1:0] pad;
        logic [HDR_N_W-1:0]   pixel_num;
    } hdr_word_t;

    function automatic hdr_word_t make_hdr(input logic [HDR_CNT_W-1:0] cnt,
                                           input logic [HDR_N_W-1:0]   n);
        hdr_word_t h;
        h.frame_cnt = cnt;
        h.pad       = '0;
        h.pixel_num = n;
        return h;
    endfunction

endpackage

// File: rtl/adc_pixel_asm.sv
// Byte-pair to pixel assembler: first byte of a pair is the MSB, second the LSB.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr_in          - return the byte phase to MSB (new frame)
//   byte_in         - ADC byte
//   byte_valid_in   - byte qualifier (already gated by the parent)
//   pixel_c         - {held MSB, current byte}; valid only with pixel_valid_c
//   pixel_valid_c   - pixel completes this cycle (combinational)
module adc_pixel_asm
    import adc_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_in,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid_in,
    output logic [PIX_W-1:0]  pixel_c,
    output logic              pixel_valid_c
);

    logic              phase_q, phase_d;   // 0: expecting MSB, 1: expecting LSB
    logic [BYTE_W-1:0] msb_q, msb_d;

    // Phase toggle and MSB capture
    always_comb begin
        phase_d       = phase_q;
        msb_d         = msb_q;
        pixel_valid_c = 1'b0;
        pixel_c       = {msb_q, byte_in};
        if (clr_in) begin
            phase_d = 1'b0;
        end else if (byte_valid_in) begin
            if (!phase_q) begin
                msb_d   = byte_in;
                phase_d = 1'b1;
            end else begin
                pixel_valid_c = 1'b1;
                phase_d       = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= 1'b0;
            msb_q   <= '0;
        end else begin
            phase_q <= phase_d;
            msb_q   <= msb_d;
        end
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Packs AD9826 byte pairs into 16-bit pixels, two pixels per 32-bit BRAM word,
// one frame per start pulse, with a done pulse and frame/drop counters.
// Optional: define ADC_PACK_HDR_EN to write a header word {frames, 6'd0, n}
// at BASE_ADDR after the data (data then starts at BASE_ADDR+4).
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   start_in       - arm a frame (IDLE only); pixel_num_in latched with it
//   byte_in/byte_valid_in - ADC byte stream, MSB byte first
//   ram_wr_o/ram_addr_o/ram_data_o - registered BRAM write port
//   busy_o, done_o - frame in progress / one-cycle completion pulse
//   frame_cnt_o    - completed frames (wrapping)
//   drop_cnt_o     - bytes seen outside collection (saturating)
module adc_frame_packer
    import adc_pack_pkg::*;
#(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned MAX_PIXELS = 512
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_in,
    input  logic [PIX_NUM_W-1:0]   pixel_num_in,
    input  logic [BYTE_W-1:0]      byte_in,
    input  logic                   byte_valid_in,
    output logic                   ram_wr_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [WORD_W-1:0]      ram_data_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o,
    output logic [DROP_CNT_W-1:0]  drop_cnt_o
);

`ifdef ADC_PACK_HDR_EN
    localparam int unsigned MAX_PIXELS_EFF = MAX_PIXELS - 2;
    localparam int unsigned DATA_OFFSET    = BYTES_PER_WORD;
`else
    localparam int unsigned MAX_PIXELS_EFF = MAX_PIXELS;
    localparam int unsigned DATA_OFFSET    = 0;
`endif
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] DATA_A = ADDR_W'(BASE_ADDR + DATA_OFFSET);

    state_e                 state_q, state_d;
    logic [PIX_NUM_W-1:0]   n_q, n_d;
    logic [PIX_NUM_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [PIX_W-1:0]       word_lo_q, word_lo_d;
    logic [ADDR_W-1:0]      waddr_q, waddr_d;
    logic                   ram_wr_q, ram_wr_d;
    logic [ADDR_W-1:0]      ram_addr_q, ram_addr_d;
    logic [WORD_W-1:0]      ram_data_q, ram_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [DROP_CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [PIX_NUM_W-1:0]   n_eff_c;
    logic                   asm_clr_c;
    logic                   asm_valid_c;
    logic [PIX_W-1:0]       pixel_c;
    logic                   pixel_valid_c;
    logic                   last_pix_c;

    assign n_eff_c     = (pixel_num_in > PIX_NUM_W'(MAX_PIXELS_EFF)) ?
                         PIX_NUM_W'(MAX_PIXELS_EFF) : pixel_num_in;
    assign asm_valid_c = byte_valid_in && (state_q == ST_COLLECT);
    assign last_pix_c  = (pix_cnt_q == (n_q - PIX_NUM_W'(1)));

    adc_pixel_asm u_pixel_asm (
        .clk           (clk),
        .rst           (rst),
        .clr_in        (asm_clr_c),
        .byte_in       (byte_in),
        .byte_valid_in (asm_valid_c),
        .pixel_c       (pixel_c),
        .pixel_valid_c (pixel_valid_c)
    );

    // Next-state, word packing, addressing and counters
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        pix_cnt_d   = pix_cnt_q;
        word_lo_d   = word_lo_q;
        waddr_d     = waddr_q;
        ram_wr_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        asm_clr_c   = 1'b0;

        if (byte_valid_in && (state_q != ST_COLLECT) && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    n_d       = n_eff_c;
                    pix_cnt_d = '0;
                    waddr_d   = DATA_A;
                    asm_clr_c = 1'b1;
                    if (n_eff_c == '0) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                    end else begin
                        state_d = ST_COLLECT;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_COLLECT: begin
                if (pixel_valid_c) begin
                    pix_cnt_d = pix_cnt_q + PIX_NUM_W'(1);
                    if (!pix_cnt_q[0]) begin
                        word_lo_d = pixel_c;
                    end
                    // Odd pixel closes a word; a trailing even pixel is padded
                    if (pix_cnt_q[0] || last_pix_c) begin
                        ram_wr_d   = 1'b1;
                        ram_addr_d = waddr_q;
                        ram_data_d = pix_cnt_q[0] ? {pixel_c, word_lo_q}
                                                  : {PIX_W'(0), pixel_c};
                        waddr_d    = waddr_q + ADDR_W'(BYTES_PER_WORD);
                    end
                    if (last_pix_c) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
`ifdef ADC_PACK_HDR_EN
                state_d    = ST_HDR;
                ram_wr_d   = 1'b1;
                ram_addr_d = BASE_A;
                ram_data_d = make_hdr(frame_cnt_q + FRAME_CNT_W'(1), n_q);
`else
                state_d     = ST_DONE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
`endif
            end
`ifdef ADC_PACK_HDR_EN
            ST_HDR: begin
                state_d     = ST_DONE;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            n_q         <= '0;
            pix_cnt_q   <= '0;
            word_lo_q   <= '0;
            waddr_q     <= DATA_A;
            ram_wr_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            pix_cnt_q   <= pix_cnt_d;
            word_lo_q   <= word_lo_d;
            waddr_q     <= waddr_d;
            ram_wr_q    <= ram_wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign ram_wr_o    = ram_wr_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = frame_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Scoreboard bench for adc_frame_packer: the driver pushes expected RAM writes
// and done events (value + cycle) computed from the byte stream; a negedge
// monitor pops and compares whenever the DUT writes or signals done.
module tb_adc_frame_packer;

`ifdef ADC_PACK_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif
    localparam int BASE      = 0;
    localparam int DATA_BASE = BASE + (HDR ? 4 : 0);
    localparam int MAX_EFF   = 512 - (HDR ? 2 : 0);

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [9:0]  pixel_num_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        ram_wr_o;
    logic [9:0]  ram_addr_o;
    logic [31:0] ram_data_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] frame_cnt_o;
    logic [7:0]  drop_cnt_o;

    adc_frame_packer dut (
        .clk           (clk),
        .rst           (rst),
        .start_in      (start_in),
        .pixel_num_in  (pixel_num_in),
        .byte_in       (byte_in),
        .byte_valid_in (byte_valid_in),
        .ram_wr_o      (ram_wr_o),
        .ram_addr_o    (ram_addr_o),
        .ram_data_o    (ram_data_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .frame_cnt_o   (frame_cnt_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    typedef struct {
        logic [15:0] fc;
        int          cyc;
    } done_t;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [7:0]  frame_bytes[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          writes_seen = 0;
    logic [9:0]  max_wr_addr = '0;
    bit          mon_off = 1'b0;
    logic [15:0] exp_frames = '0;
    int          exp_drop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every write / done
    always @(negedge clk) begin
        if (!rst && !mon_off) begin
            if (ram_wr_o) begin
                writes_seen++;
                if (ram_addr_o > max_wr_addr) max_wr_addr = ram_addr_o;
                chk("busy_on_wr", 32'(busy_o), 32'd1);
                if (exp_wr.size() == 0) begin
                    chk("unexpected_wr_addr", 32'(ram_addr_o), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 32'(ram_addr_o), 32'(e.addr));
                    chk("wr_data", ram_data_o, e.data);
                    chk("wr_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
            if (done_o) begin
                chk("busy_at_done", 32'(busy_o), 32'd0);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("frame_cnt", 32'(frame_cnt_o), 32'(d.fc));
                    chk("done_cycle", 32'(cyc), 32'(d.cyc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int nbytes);
        frame_bytes.delete();
        for (int i = 0; i < nbytes; i++) frame_bytes.push_back(8'($urandom));
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 64 && exp_done.size() != 0; i++) tick();
        chk(name, 32'(exp_done.size()), 32'd0);
        tick();
    endtask

    // One frame: start, then 2n bytes with optional gaps; expectations derived
    // from the pixel list (pairs of pixels per word, odd count zero-padded).
    task automatic run_frame(input int pnum, input int max_gap,
                             input bit start_byte, input int spur_at);
        int          n;
        logic [15:0] pix, prev_pix;
        int          k;
        n = (pnum > MAX_EFF) ? MAX_EFF : pnum;
        prev_pix = '0;
        start_in      = 1'b1;
        pixel_num_in  = 10'(pnum);
        byte_in       = 8'hAA;
        byte_valid_in = start_byte;
        if (start_byte) exp_drop = (exp_drop >= 255) ? 255 : exp_drop + 1;
        if (n == 0) begin
            exp_frames = exp_frames + 16'd1;
            exp_done.push_back('{fc: exp_frames, cyc: cyc + 1});
        end
        tick();
        start_in      = 1'b0;
        byte_valid_in = 1'b0;
        for (int b = 0; b < 2 * n; b++) begin
            int gap;
            gap = (max_gap > 0) ? $urandom_range(max_gap, 1) : 0;
            repeat (gap) tick();
            byte_in       = frame_bytes[b];
            byte_valid_in = 1'b1;
            if (b == spur_at) begin
                start_in     = 1'b1;
                pixel_num_in = 10'd7;
            end
            if (b % 2 == 1) begin
                pix = {frame_bytes[b-1], frame_bytes[b]};
                k   = b / 2;
                if (k % 2 == 1)
                    exp_wr.push_back('{addr: 10'(DATA_BASE + 4 * (k / 2)),
                                       data: {pix, prev_pix}, cyc: cyc + 1});
                else if (k == n - 1)
                    exp_wr.push_back('{addr: 10'(DATA_BASE + 4 * (k / 2)),
                                       data: {16'h0000, pix}, cyc: cyc + 1});
                prev_pix = pix;
            end
            if (b == 2 * n - 1) begin
                exp_frames = exp_frames + 16'd1;
                if (HDR)
                    exp_wr.push_back('{addr: 10'(BASE),
                                       data: {exp_frames, 6'd0, 10'(n)}, cyc: cyc + 2});
                exp_done.push_back('{fc: exp_frames, cyc: cyc + (HDR ? 3 : 2)});
            end
            tick();
            byte_valid_in = 1'b0;
            start_in      = 1'b0;
        end
        wait_done("done_pending");
    endtask

    task automatic check_zero_outputs();
        @(negedge clk);
        chk("rst_ram_wr",    32'(ram_wr_o),    32'd0);
        chk("rst_ram_addr",  32'(ram_addr_o),  32'd0);
        chk("rst_ram_data",  ram_data_o,       32'd0);
        chk("rst_busy",      32'(busy_o),      32'd0);
        chk("rst_done",      32'(done_o),      32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt_o),  32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_in = 1'b0; pixel_num_in = '0;
        byte_in = '0; byte_valid_in = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_zero_outputs();
        tick();

        // n=4 back-to-back, with a byte on the start cycle that must be dropped
        frame_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        run_frame(4, 0, 1'b1, -1);
        chk("drop_start_byte", 32'(drop_cnt_o), 32'(exp_drop));

        // n=3 gapped
        frame_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame(3, 2, 1'b0, -1);

        // n=0: no writes, immediate done
        frame_bytes.delete();
        run_frame(0, 0, 1'b0, -1);
        chk("frame_cnt_after_n0", 32'(frame_cnt_o), 32'(exp_frames));

        // Random frames, each with a start pulse while busy
        for (int f = 0; f < 6; f++) begin
            int pn;
            pn = $urandom_range(24, 1);
            fill_random(2 * pn);
            run_frame(pn, (f % 2 == 0) ? 0 : 3, 1'b0, $urandom_range(2 * pn - 1, 0));
        end
        chk("drop_after_frames", 32'(drop_cnt_o), 32'(exp_drop));

        // Clamp: 1023 requested, full RAM written, no address wrap
        writes_seen = 0;
        max_wr_addr = '0;
        fill_random(2 * MAX_EFF);
        run_frame(1023, 0, 1'b0, -1);
        chk("clamp_writes", 32'(writes_seen), 32'd256);
        chk("clamp_max_addr", 32'(max_wr_addr), 32'h3FC);

        // 300 stray bytes in IDLE saturate the drop counter
        for (int i = 0; i < 300; i++) begin
            byte_in = 8'($urandom);
            byte_valid_in = 1'b1;
            tick();
        end
        byte_valid_in = 1'b0;
        exp_drop = (exp_drop + 300 > 255) ? 255 : exp_drop + 300;
        tick();
        chk("drop_saturate", 32'(drop_cnt_o), 32'(exp_drop));
        chk("no_pending_wr", 32'(exp_wr.size()), 32'd0);

        // Reset in the middle of a frame
        mon_off = 1'b1;
        start_in = 1'b1; pixel_num_in = 10'd8;
        tick();
        start_in = 1'b0;
        for (int b = 0; b < 5; b++) begin
            byte_in = 8'($urandom); byte_valid_in = 1'b1;
            tick();
        end
        byte_valid_in = 1'b0;
        chk("busy_mid_frame", 32'(busy_o), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_wr.delete();
        exp_done.delete();
        exp_frames = '0;
        exp_drop = 0;
        check_zero_outputs();
        mon_off = 1'b0;
        tick();

        frame_bytes = '{8'hCA, 8'hFE, 8'hBE, 8'hEF};
        run_frame(2, 1, 1'b0, -1);
        chk("final_pending_wr", 32'(exp_wr.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
